// File: rtl/dircc_counter_send_handler_pkg.sv
// Shared types for the counter device send path: generic device/packet types,
// counter application state layout and system state flag masks.
package dircc_types_pkg;

  typedef logic [31:0] packet_data_t;

  typedef struct packed {
    logic [31:0] user_state;
    logic [31:0] dircc_state;
    logic [31:0] dircc_state_extra;
  } device_state_t;

endpackage

package dircc_system_states_pkg;

  localparam logic [31:0] DIRCC_STATE_DONE    = 32'h0000_0001;
  localparam logic [31:0] DIRCC_STATE_STOPPED = 32'h0000_0002;

endpackage

package dircc_application_pkg;

  typedef struct packed {
    logic [15:0] rts;
    logic [15:0] count;
  } counter_dev_state_t;

  typedef struct packed {
    logic [31:0] tick;
  } tick_msg_t;

  typedef enum logic [1:0] {StIdle, StSend, StCommit} send_state_e;

  // Write-back form of the user state: rts cleared, count untouched.
  function automatic logic [31:0] clear_rts(input logic [31:0] user_state);
    counter_dev_state_t s;
    s     = counter_dev_state_t'(user_state);
    s.rts = '0;
    return s;
  endfunction

endpackage

// File: rtl/dircc_dest_gen.sv
// Combinational destination generator: (address + index + 1) mod NUM_DEVICES,
// evaluated one bit wider than the address so the sum cannot overflow.
module dircc_dest_gen #(
  parameter int unsigned ADDRESS_MEM_WIDTH = 32,
  parameter int unsigned NUM_DEVICES       = 4,
  parameter int unsigned IDX_WIDTH         = 1
) (
  input  logic [ADDRESS_MEM_WIDTH-1:0] address_i,
  input  logic [IDX_WIDTH-1:0]         index_i,
  output logic [ADDRESS_MEM_WIDTH-1:0] dest_o
);

  localparam int unsigned SumW = ADDRESS_MEM_WIDTH + 1;

  if (NUM_DEVICES == 1) begin : gen_single
    logic unused_index;
    assign unused_index = ^index_i;
    assign dest_o       = address_i;
  end else begin : gen_wrap
    logic [SumW-1:0] sum;
    assign sum    = {1'b0, address_i} + SumW'(index_i) + SumW'(1);
    assign dest_o = ADDRESS_MEM_WIDTH'(sum % SumW'(NUM_DEVICES));
  end

endmodule

// File: rtl/dircc_counter_send_handler.sv
// Counter device send handler: on a pending rts, fans out one tick packet per neighbour,
// then writes the state back with rts cleared. DIRCC_SEND_STATS_EN adds send_count_o.
module dircc_counter_send_handler
  import dircc_types_pkg::*;
  import dircc_system_states_pkg::*;
  import dircc_application_pkg::*;
#(
  parameter int unsigned ADDRESS_MEM_WIDTH = 32,
  parameter int unsigned NUM_OUTPUTS       = 2,
  parameter int unsigned NUM_DEVICES       = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address_i,
  input  device_state_t                read_state_i,
  input  logic                         read_state_valid_i,
  input  logic                         send_ready_i,
  output packet_data_t                 packet_out_o,
  output logic [ADDRESS_MEM_WIDTH-1:0] packet_out_dest_o,
  output logic                         packet_out_valid_o,
  output device_state_t                write_state_o,
  output logic                         write_state_valid_o,
  output logic                         busy_o
`ifdef DIRCC_SEND_STATS_EN
  ,
  output logic [31:0]                  send_count_o
`endif
);

  localparam int unsigned IdxW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OUTPUTS - 1);

  send_state_e        state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  device_state_t      snap_q, snap_d;
  counter_dev_state_t rd_user, snap_user;
  logic               trigger;
  logic [ADDRESS_MEM_WIDTH-1:0] dest;
  tick_msg_t          tick_msg;

  assign rd_user   = counter_dev_state_t'(read_state_i.user_state);
  assign snap_user = counter_dev_state_t'(snap_q.user_state);
  assign trigger   = read_state_valid_i && (rd_user.rts != '0) &&
                     ((read_state_i.dircc_state & (DIRCC_STATE_DONE | DIRCC_STATE_STOPPED)) == '0);

  dircc_dest_gen #(
    .ADDRESS_MEM_WIDTH (ADDRESS_MEM_WIDTH),
    .NUM_DEVICES       (NUM_DEVICES),
    .IDX_WIDTH         (IdxW)
  ) u_dest_gen (
    .address_i (address_i),
    .index_i   (idx_q),
    .dest_o    (dest)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          snap_d  = read_state_i;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (send_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d = StCommit;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Outputs decode straight from state so an async reset drops valid immediately.
  always_comb begin
    tick_msg            = '{tick: {16'h0, snap_user.count}};
    packet_out_valid_o  = (state_q == StSend);
    packet_out_o        = packet_out_valid_o ? packet_data_t'(tick_msg) : '0;
    packet_out_dest_o   = packet_out_valid_o ? dest : '0;
    write_state_valid_o = (state_q == StCommit);
    write_state_o       = '0;
    if (write_state_valid_o) begin
      write_state_o            = snap_q;
      write_state_o.user_state = clear_rts(snap_q.user_state);
    end
    busy_o = (state_q != StIdle);
  end

`ifdef DIRCC_SEND_STATS_EN
  logic [31:0] send_count_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      send_count_q <= '0;
    end else if (packet_out_valid_o && send_ready_i) begin
      send_count_q <= send_count_q + 32'd1;
    end
  end

  assign send_count_o = send_count_q;
`endif

endmodule

// File: tb/tb_dircc_counter_send_handler.sv
// Self-checking bench: queue-based model of expected packets and write-backs,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dircc_counter_send_handler;
  import dircc_types_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned NO = 2;
  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  device_state_t read_state = '0;
  logic          read_state_valid = 1'b0;
  logic          send_ready = 1'b0;
  packet_data_t  packet_out;
  logic [AW-1:0] packet_out_dest;
  logic          packet_out_valid;
  device_state_t write_state;
  logic          write_state_valid;
  logic          busy;
`ifdef DIRCC_SEND_STATS_EN
  logic [31:0]   send_count;
`endif

  always #5 clk = ~clk;

  dircc_counter_send_handler #(
    .ADDRESS_MEM_WIDTH (AW),
    .NUM_OUTPUTS       (NO),
    .NUM_DEVICES       (ND)
  ) dut (
    .clk_i               (clk),
    .reset_ni            (reset_n),
    .address_i           (address),
    .read_state_i        (read_state),
    .read_state_valid_i  (read_state_valid),
    .send_ready_i        (send_ready),
    .packet_out_o        (packet_out),
    .packet_out_dest_o   (packet_out_dest),
    .packet_out_valid_o  (packet_out_valid),
    .write_state_o       (write_state),
    .write_state_valid_o (write_state_valid),
    .busy_o              (busy)
`ifdef DIRCC_SEND_STATS_EN
    ,
    .send_count_o        (send_count)
`endif
  );

  typedef struct {
    bit            is_wb;
    logic [31:0]   tick;
    logic [AW-1:0] dest;
    device_state_t ws;
  } item_t;

  item_t       q[$];
  int unsigned exp_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned dut_xfers = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic device_state_t mk(input logic [15:0] rts, input logic [15:0] cnt,
                                       input logic [31:0] ds, input logic [31:0] ext);
    device_state_t s;
    s.user_state        = {rts, cnt};
    s.dircc_state       = ds;
    s.dircc_state_extra = ext;
    return s;
  endfunction

  function automatic logic [AW-1:0] model_dest(input logic [AW-1:0] a, input int unsigned i);
    longint unsigned s;
    if (ND == 1) return a;
    s = longint'(a) + longint'(i) + 1;
    return AW'(s % ND);
  endfunction

  task automatic compare_model();
    bit b, v, w;
    b = (q.size() != 0);
    v = b && !q[0].is_wb;
    w = b && q[0].is_wb;
    check("busy", busy, b);
    check("packet_out_valid", packet_out_valid, v);
    check("write_state_valid", write_state_valid, w);
    if (v) begin
      check("packet_out.tick", packet_out, q[0].tick);
      check("packet_out_dest", packet_out_dest, q[0].dest);
    end
    if (w) check("write_state", write_state, q[0].ws);
`ifdef DIRCC_SEND_STATS_EN
    check("send_count", send_count, exp_cnt);
`endif
  endtask

  task automatic next_cycle();
    @(negedge clk);
    compare_model();
  endtask

  // Drive inputs for the coming posedge and advance the model by the same cycle.
  task automatic apply(input bit rsv, input device_state_t rs, input bit rdy);
    item_t it;
    read_state_valid = rsv;
    read_state       = rs;
    send_ready       = rdy;
    if (packet_out_valid && rdy) dut_xfers++;
    if (!reset_n) return;
    if (q.size() != 0) begin
      if (q[0].is_wb) void'(q.pop_front());
      else if (rdy) begin
        void'(q.pop_front());
        exp_cnt++;
      end
    end else if (rsv && rs.user_state[31:16] != 0 && (rs.dircc_state & 32'h3) == 0) begin
      for (int i = 0; i < NO; i++) begin
        it       = '{is_wb: 1'b0, tick: {16'h0, rs.user_state[15:0]},
                     dest: model_dest(address, i), ws: '0};
        q.push_back(it);
      end
      it                 = '{is_wb: 1'b1, tick: '0, dest: '0, ws: rs};
      it.ws.user_state   = {16'h0, rs.user_state[15:0]};
      q.push_back(it);
    end
  endtask

  // Call right after apply(): reset asserts between the negedge and the next posedge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst.valid_async", packet_out_valid, 1'b0);
    check("rst.busy_async", busy, 1'b0);
    check("rst.wsv_async", write_state_valid, 1'b0);
    q.delete();
    exp_cnt = 0;
    next_cycle();
    apply(1'b0, '0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic idle_until_free(input bit rdy);
    for (int i = 0; i < 20 && (q.size() != 0 || busy); i++) begin
      next_cycle();
      apply(1'b0, '0, rdy);
    end
    next_cycle();
    check("returned_idle", busy, 1'b0);
  endtask

  initial begin
    logic [31:0] held_pkt;
    logic [AW-1:0] held_dest;

    // Reset values
    next_cycle();
    check("reset.packet_out", packet_out, 32'h0);
    check("reset.dest", packet_out_dest, '0);
    check("reset.write_state", write_state, '0);
    apply(1'b0, '0, 1'b0);
    reset_n = 1'b1;

    // Basic send: address 3, rts 1, count 5
    next_cycle();
    address = 32'd3;
    apply(1'b1, mk(16'h1, 16'h5, 32'h0, 32'hA5A5_0000), 1'b1);
    next_cycle();
    check("t2.valid0", packet_out_valid, 1'b1);
    check("t2.tick0", packet_out, 32'h5);
    check("t2.dest0", packet_out_dest, 32'd0);
    apply(1'b0, '0, 1'b1);
    next_cycle();
    check("t2.valid1", packet_out_valid, 1'b1);
    check("t2.dest1", packet_out_dest, 32'd1);
    apply(1'b0, '0, 1'b1);
    next_cycle();
    check("t2.wsv", write_state_valid, 1'b1);
    check("t2.ws_user", write_state.user_state, 32'h0000_0005);
    check("t2.ws_extra", write_state.dircc_state_extra, 32'hA5A5_0000);
    apply(1'b0, '0, 1'b1);
    next_cycle();
    check("t2.wsv_pulse", write_state_valid, 1'b0);
    check("t2.idle", busy, 1'b0);
    apply(1'b0, '0, 1'b0);

    // Backpressure: ready low 4 cycles, packet held stable
    address = 32'd1;
    next_cycle();
    dut_xfers = 0;
    apply(1'b1, mk(16'h7, 16'hBEEF, 32'h0, 32'h0), 1'b0);
    next_cycle();
    held_pkt  = packet_out;
    held_dest = packet_out_dest;
    check("t3.dest_first", held_dest, 32'd2);
    apply(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("t3.pkt_stable", packet_out, held_pkt);
      check("t3.dest_stable", packet_out_dest, held_dest);
      apply(1'b0, '0, 1'b0);
    end
    idle_until_free(1'b1);
    check("t3.xfers", dut_xfers, NO);
    apply(1'b0, '0, 1'b0);

    // DONE / STOPPED suppress sending
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("t4.no_valid", packet_out_valid, 1'b0);
      check("t4.no_wsv", write_state_valid, 1'b0);
      apply(1'b1, mk(16'h1, 16'h3, 32'(i % 3 + 1), 32'h0), 1'b1);
    end

    // Snapshot isolation: count changes to 9 mid-send
    address = 32'd0;
    next_cycle();
    apply(1'b1, mk(16'h1, 16'h5, 32'h0, 32'h0), 1'b0);
    next_cycle();
    check("t5.tick0", packet_out, 32'h5);
    apply(1'b1, mk(16'h1, 16'h9, 32'h0, 32'h0), 1'b1);
    next_cycle();
    check("t5.tick1", packet_out, 32'h5);
    apply(1'b1, mk(16'h1, 16'h9, 32'h0, 32'h0), 1'b1);
    next_cycle();
    check("t5.wb_count", write_state.user_state, 32'h0000_0005);
    apply(1'b0, '0, 1'b0);

    // Reset mid-SEND under backpressure
    next_cycle();
    apply(1'b1, mk(16'h2, 16'h44, 32'h0, 32'h0), 1'b0);
    next_cycle();
    check("t1.valid_before", packet_out_valid, 1'b1);
    apply(1'b0, '0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("t1.no_wsv", write_state_valid, 1'b0);
      apply(1'b0, '0, 1'b1);
    end

`ifdef DIRCC_SEND_STATS_EN
    // Three full sends count 3 * NUM_OUTPUTS transfers
    do_reset();
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      apply(1'b1, mk(16'h1, 16'(s), 32'h0, 32'h0), 1'b1);
      idle_until_free(1'b1);
      apply(1'b0, '0, 1'b1);
    end
    next_cycle();
    check("t6.send_count", send_count, 32'd6);
    apply(1'b0, '0, 1'b0);
`endif

    // Randomized traffic, including addresses near the top of the range
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] rts;
      logic [15:0] cnt;
      logic [31:0] ds;
      next_cycle();
      if (q.size() == 0 && $urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: address = 32'hFFFF_FFFF;
          1: address = 32'hFFFF_FFFE;
          default: address = $urandom;
        endcase
      end
      rts = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cnt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ds  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) ds = ds | 32'($urandom_range(1, 3));
      apply($urandom_range(0, 2) != 0, mk(rts, cnt, ds, $urandom), $urandom_range(0, 9) < 7);
    end
    idle_until_free(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
